score_text_encoder: RTL and testbench
=====================================

Name: score_text_encoder

Overview:
Converts a binary score or counter value into a packed ASCII decimal string for the on-screen text renderer. Its TEXT-format output is MSB-first, 8 bits per character. Conversion is iterative double-dabble (shift-add-3), driven by a start/busy/done handshake. The output string register changes only once per conversion, so the pixel renderer never sees a partially converted value mid-frame. It sits between the game-logic score counters and the string renderer.

Parameters:
BIN_W, 10, width of the binary input value (1..16)
DIGITS, 3, number of decimal characters produced (1..5)
BLANK_ZEROS, 1, 1 = leading zeros become ASCII space 0x20; 0 = keep leading '0'

Ports:
clk_0  in  1  system clock
rst  in  1  asynchronous reset, active-low
start  in  1  request conversion of value; sampled only in IDLE
value  in  BIN_W  binary value to convert; captured on the accepted start edge
busy  out  1  high while a conversion is in progress
done  out  1  single-cycle pulse when text has been updated
overflow  out  1  set when the last converted value exceeded 10^DIGITS-1
text  out  DIGITS*8  ASCII string, character 0 in bits [DIGITS*8-1 -: 8]

Behaviour:
- Reset is asynchronous and active-low: rst low immediately forces all state and outputs.
- Reset values:
  - busy=0, done=0, overflow=0.
  - text = (DIGITS-1) spaces followed by '0' (0x30) when BLANK_ZEROS=1; all '0' when BLANK_ZEROS=0.
  - FSM = IDLE; shift and BCD registers = 0.
- FSM states: IDLE, SHIFT, FORMAT.
- IDLE:
  - start=1 at edge k: latch value into the shift register, clear the BCD register (DIGITS*4 bits), load bit counter = BIN_W.
  - Latch ovf_pending = (value > 10^DIGITS-1), compared at full BIN_W width.
  - busy=1 from edge k. Go to SHIFT.
- SHIFT, one bit per cycle:
  - Each BCD nibble >=5 first gets +3.
  - Then {bcd, shift} shifts left by 1, shifting in the shift-register MSB.
  - Counter decrements; on the edge where it reaches 0, go to FORMAT.
  - Exactly BIN_W cycles in SHIFT (edges k+1..k+BIN_W).
  - BCD bits beyond DIGITS nibbles are discarded; overflow is handled by ovf_pending only.
- FORMAT, one cycle (edge k+BIN_W+1):
  - Write text: each nibble becomes 0x30+nibble.
  - If BLANK_ZEROS, every leading '0' becomes 0x20; the least-significant character is never blanked.
  - If ovf_pending: text = all '9', overflow=1; otherwise overflow=0.
  - done=1 for exactly one cycle (from edge k+BIN_W+1 to k+BIN_W+2). busy=0 from the same edge. Return to IDLE.
- Latency: start edge to done asserted = BIN_W+1 clocks. Back-to-back start is accepted on the edge after done (IDLE).
- start while busy is ignored (no queueing). value changes during conversion have no effect.
- text and overflow hold their previous values throughout SHIFT; they change only at FORMAT.
- Reset mid-conversion aborts the conversion: outputs return to reset values, and no done pulse is generated.
- start held high continuously: a new conversion starts each time IDLE is re-entered. Period = BIN_W+2 clocks.

Test Plan:
- Reset release, no start: text = "  0" (0x20,0x20,0x30), busy=0, done=0, overflow=0.
- start with value=7: done exactly 11 clocks after the start edge; text = "  7"; busy high for 11 cycles; done pulse 1 cycle wide.
- value=105, then value=999 after done: text = "105", then "999"; overflow=0. With BLANK_ZEROS=0, value=7 gives "007".
- value=1000 and value=1023: text = "999", overflow=1. A following value=42 gives " 42", overflow=0.
- Start pulses at cycles 3 and 5 of a conversion (value changed to 500): ignored; result still reflects the first value. text stays at the old string until the FORMAT edge.
- rst asserted at cycle 6 of a conversion: busy, done and text immediately return to reset values. The next start with value=0 gives "  0" after 11 clocks.

Source files
------------

// File: rtl/score_text_encoder_if.sv
// Handshake bundle between the score logic and score_text_encoder.
// start is a request level that is honoured only while the encoder is idle (busy=0).
// busy covers the accepted start edge through the edge that updates text.
// done pulses for one cycle on that update edge.
// text and overflow are valid from the done pulse until the next done pulse.
interface score_text_encoder_if #(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      value;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [DIGITS*8-1:0]   text;
    logic [1:0]            state_dbg;

    modport master (
        output start, value,
        input  busy, done, overflow, text, state_dbg
    );

    modport slave (
        input  start, value,
        output busy, done, overflow, text, state_dbg
    );
endinterface

// File: rtl/score_text_encoder.sv
// Binary to packed ASCII decimal converter using iterative double-dabble.
// The text register is written only once, at the end of each conversion.
module score_text_encoder #(
    parameter int BIN_W       = 10,
    parameter int DIGITS      = 3,
    parameter bit BLANK_ZEROS = 1'b1
) (
    input  logic                clk_0,
    input  logic                rst,
    score_text_encoder_if.slave bus
);
    localparam int CNT_W   = $clog2(BIN_W + 1);
    localparam int MAX_VAL = (10 ** DIGITS) - 1;

    function automatic logic [DIGITS*8-1:0] idle_text();
        logic [DIGITS*8-1:0] t;
        for (int i = 0; i < DIGITS; i++) begin
            t[i*8 +: 8] = (i == 0 || !BLANK_ZEROS) ? 8'h30 : 8'h20;
        end
        return t;
    endfunction

    localparam logic [DIGITS*8-1:0] RST_TEXT = idle_text();

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, FORMAT = 2'd2} state_t;

    state_t                state_q, state_d;
    logic [BIN_W-1:0]      shift_q, shift_d;
    logic [DIGITS*4-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ovf_pend_q, ovf_pend_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  overflow_q, overflow_d;
    logic [DIGITS*8-1:0]   text_q, text_d;

    logic [DIGITS*4-1:0]   adj;
    logic [DIGITS*8-1:0]   fmt;
    logic                  leading;
    logic [3:0]            nib;

    always_comb begin
        adj     = bcd_q;
        fmt     = '0;
        leading = 1'b1;
        nib     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
        // Character 0 sits in the top byte; only the last character is exempt from blanking.
        for (int i = 0; i < DIGITS; i++) begin
            nib = bcd_q[(DIGITS-1-i)*4 +: 4];
            if (BLANK_ZEROS && leading && nib == 4'd0 && i != DIGITS-1) begin
                fmt[(DIGITS-1-i)*8 +: 8] = 8'h20;
            end else begin
                leading = 1'b0;
                fmt[(DIGITS-1-i)*8 +: 8] = 8'h30 + {4'd0, nib};
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        text_d     = text_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shift_d    = bus.value;
                    bcd_d      = '0;
                    cnt_d      = CNT_W'(BIN_W);
                    ovf_pend_d = (32'(bus.value) > 32'(MAX_VAL));
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, shift_d} = {adj, shift_q} << 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = FORMAT;
            end
            FORMAT: begin
                text_d     = ovf_pend_q ? {DIGITS{8'h39}} : fmt;
                overflow_d = ovf_pend_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            text_q     <= RST_TEXT;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            text_q     <= text_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.overflow  = overflow_q;
    assign bus.text      = text_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_score_text_encoder.sv
// Self-checking bench for score_text_encoder: vector table, randomized model
// comparison and hand-written multi-cycle sequences.
module tb_score_text_encoder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  score_text_encoder_if #(.BIN_W(10), .DIGITS(3)) bus ();
  score_text_encoder_if #(.BIN_W(10), .DIGITS(3)) bus0 ();

  score_text_encoder #(.BIN_W(10), .DIGITS(3), .BLANK_ZEROS(1'b1)) u_dut (
    .clk_0(clk), .rst(rst), .bus(bus)
  );
  score_text_encoder #(.BIN_W(10), .DIGITS(3), .BLANK_ZEROS(1'b0)) u_dut0 (
    .clk_0(clk), .rst(rst), .bus(bus0)
  );

  typedef struct {
    int          value;
    logic [23:0] exp_text;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Decimal digits from plain division; overflow saturates to all nines.
  function automatic logic [23:0] model_text(input int v, input bit blank);
    logic [23:0] t;
    int d[3];
    bit lead;
    if (v > 999) return "999";
    d[0] = v / 100; d[1] = (v / 10) % 10; d[2] = v % 10;
    lead = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (blank && lead && d[i] == 0 && i != 2) t[(2-i)*8 +: 8] = 8'h20;
      else begin lead = 1'b0; t[(2-i)*8 +: 8] = 8'h30 + 8'(d[i]); end
    end
    return t;
  endfunction

  task automatic convert(input int v, input logic [23:0] exp_text, input logic exp_ovf,
                         input bit inject);
    logic [23:0] prev;
    int n, busy_n;
    bit seen, moved;
    prev = bus.text;
    n = 0; busy_n = 0; seen = 1'b0; moved = 1'b0;
    bus.value = 10'(v);
    bus.start = 1'b1;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) bus.start = 1'b0;
      if (inject && (n == 3 || n == 5)) begin bus.start = 1'b1; bus.value = 10'd500; end
      if (inject && (n == 4 || n == 6)) bus.start = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.done) seen = 1'b1;
      else if (bus.text !== prev) moved = 1'b1;
    end
    chk("latency", 32'(n - 1), 32'd11);
    chk("busy_cycles", 32'(busy_n), 32'd11);
    chk("text_hold", {31'd0, moved}, 32'd0);
    chk("text", {8'd0, bus.text}, {8'd0, exp_text});
    chk("overflow", {31'd0, bus.overflow}, {31'd0, exp_ovf});
    @(negedge clk);
    chk("done_width", {31'd0, bus.done}, 32'd0);
  endtask

  task automatic convert0(input int v);
    int n;
    n = 0;
    bus0.value = 10'(v);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    while (!bus0.done && n < 40) begin @(negedge clk); n++; end
    chk("noblank_text", {8'd0, bus0.text}, {8'd0, model_text(v, 1'b0)});
    chk("noblank_ovf", {31'd0, bus0.overflow}, {31'd0, v > 999});
    @(negedge clk);
  endtask

  initial begin
    int v, n, t0, t1;
    bit got;
    vecs[0]  = '{7,    "  7", 1'b0};
    vecs[1]  = '{105,  "105", 1'b0};
    vecs[2]  = '{999,  "999", 1'b0};
    vecs[3]  = '{1000, "999", 1'b1};
    vecs[4]  = '{1023, "999", 1'b1};
    vecs[5]  = '{42,   " 42", 1'b0};
    vecs[6]  = '{0,    "  0", 1'b0};
    vecs[7]  = '{10,   " 10", 1'b0};
    vecs[8]  = '{100,  "100", 1'b0};
    vecs[9]  = '{500,  "500", 1'b0};
    vecs[10] = '{90,   " 90", 1'b0};
    vecs[11] = '{1,    "  1", 1'b0};

    bus.start = 1'b0; bus.value = '0;
    bus0.start = 1'b0; bus0.value = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_text", {8'd0, bus.text}, {8'd0, 24'h202030});
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    chk("rst_text_noblank", {8'd0, bus0.text}, {8'd0, 24'h303030});

    for (int i = 0; i < 12; i++) convert(vecs[i].value, vecs[i].exp_text, vecs[i].exp_ovf, 1'b0);

    for (int i = 0; i < 30; i++) begin
      v = int'($urandom_range(0, 1023));
      convert(v, model_text(v, 1'b1), v > 999, 1'b0);
    end

    // Starts mid-conversion with a changed value must be ignored.
    convert(105, "105", 1'b0, 1'b0);
    convert(7, "  7", 1'b0, 1'b1);

    convert0(7);
    for (int i = 0; i < 5; i++) convert0(int'($urandom_range(0, 1023)));

    // Continuous start: done pulses every BIN_W+2 clocks.
    bus.value = 10'd321;
    bus.start = 1'b1;
    n = 0; t0 = 0; t1 = 0; got = 1'b0;
    while (!got && n < 40) begin @(negedge clk); n++; if (bus.done) begin got = 1'b1; t0 = n; end end
    got = 1'b0;
    while (!got && n < 80) begin @(negedge clk); n++; if (bus.done) begin got = 1'b1; t1 = n; end end
    bus.start = 1'b0;
    chk("cont_period", 32'(t1 - t0), 32'd12);
    chk("cont_text", {8'd0, bus.text}, {8'd0, 24'h333231});
    repeat (2) @(negedge clk);

    // Reset mid-conversion after an overflow result.
    convert(1000, "999", 1'b1, 1'b0);
    bus.value = 10'd123;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_done", {31'd0, bus.done}, 32'd0);
    chk("midrst_text", {8'd0, bus.text}, {8'd0, 24'h202030});
    chk("midrst_ovf", {31'd0, bus.overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    got = 1'b0;
    repeat (20) begin @(negedge clk); if (bus.done || bus.busy) got = 1'b1; end
    chk("midrst_no_done", {31'd0, got}, 32'd0);
    convert(0, "  0", 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
